// File: rtl/riscv_defines.sv
// Shared constants and helpers for the instruction-port arbiter.
package riscv_defines;
   localparam int ARB_MAX_MASTERS = 8;

   // Id width for N masters; one bit minimum so a single-entry id still has a width.
   function automatic int arb_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/riscv_arb_id_fifo.sv
// In-order FIFO of granted master ids; head is readable combinationally.
module riscv_arb_id_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) r_mem[r_wr_ptr] <= data_i;
   end

   assign head_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;
   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port, with grant lock
// and in-order response routing back to the issuing master.
module riscv_instr_port_arbiter
   import riscv_defines::*;
#(
   parameter int N_MASTERS       = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int RDATA_WIDTH     = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_MASTERS-1:0]                 m_req_i,
   input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
   output logic [N_MASTERS-1:0]                 m_gnt_o,
   output logic [N_MASTERS-1:0]                 m_rvalid_o,
   output logic [RDATA_WIDTH-1:0]               m_rdata_o,
   output logic [N_MASTERS-1:0]                 m_err_pmp_o,
   output logic                                 instr_req_o,
   output logic [ADDR_WIDTH-1:0]                instr_addr_o,
   input  logic                                 instr_gnt_i,
   input  logic                                 instr_rvalid_i,
   input  logic [RDATA_WIDTH-1:0]               instr_rdata_i,
   input  logic                                 instr_err_pmp_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 protocol_err_o
);
   localparam int IDW = arb_id_width(N_MASTERS);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] r_lock_id;
   logic           r_locked;
   logic           r_protocol_err;
   logic [IDW-1:0] w_winner;
   logic [IDW-1:0] w_rr_next;
   logic [IDW-1:0] w_head;
   logic [CW-1:0]  w_count;
   logic           w_full;
   logic           w_empty;
   logic           w_grant;
   logic           w_pop;
   logic           w_orphan;

   always_comb begin
      int   idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      w_winner = r_rr_ptr;
      for (int i = 0; i < N_MASTERS; i++) begin
         idx = (int'(r_rr_ptr) + i) % N_MASTERS;
         if (!found && m_req_i[idx]) begin
            w_winner = IDW'(idx);
            found    = 1'b1;
         end
      end
      // A stalled request keeps the port even if a higher-priority master shows up.
      if (r_locked) w_winner = r_lock_id;
   end

   assign w_rr_next    = (int'(w_winner) == N_MASTERS - 1) ? '0 : w_winner + IDW'(1);
   assign instr_req_o  = ~rst & m_req_i[w_winner] & ~w_full;
   assign instr_addr_o = m_addr_i[w_winner];
   assign w_grant      = instr_req_o & instr_gnt_i;
   assign w_pop        = ~rst & instr_rvalid_i & ~w_empty;
   assign w_orphan     = instr_rvalid_i & w_empty;

   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_route
         assign m_gnt_o[gi]     = w_grant & (w_winner == IDW'(gi));
         assign m_rvalid_o[gi]  = w_pop & (w_head == IDW'(gi));
         assign m_err_pmp_o[gi] = w_pop & (w_head == IDW'(gi)) & instr_err_pmp_i;
      end
   endgenerate

   assign m_rdata_o      = instr_rdata_i;
   assign outstanding_o  = w_count;
   assign protocol_err_o = r_protocol_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr       <= '0;
         r_locked       <= 1'b0;
         r_lock_id      <= '0;
         r_protocol_err <= 1'b0;
      end else begin
         if (w_grant) begin
            r_rr_ptr <= w_rr_next;
            r_locked <= 1'b0;
         end else if (instr_req_o) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_winner;
         end
         if (w_orphan) r_protocol_err <= 1'b1;
      end
   end

   riscv_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDW)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_grant),
      .pop_i   (w_pop),
      .data_i  (w_winner),
      .head_o  (w_head),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );
endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Directed bench: inline checks on the request path, scoreboard-checked responses.
module tb_riscv_instr_port_arbiter;
   localparam logic [31:0] ADDR0 = 32'h1C00_0080;
   localparam logic [31:0] ADDR1 = 32'h1C00_0100;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       m_req_i;
   logic [1:0][31:0] m_addr_i;
   logic [1:0]       m_gnt_o;
   logic [1:0]       m_rvalid_o;
   logic [31:0]      m_rdata_o;
   logic [1:0]       m_err_pmp_o;
   logic             instr_req_o;
   logic [31:0]      instr_addr_o;
   logic             instr_gnt_i;
   logic             instr_rvalid_i;
   logic [31:0]      instr_rdata_i;
   logic             instr_err_pmp_i;
   logic [1:0]       outstanding_o;
   logic             protocol_err_o;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   riscv_instr_port_arbiter #(
      .N_MASTERS(2), .ADDR_WIDTH(32), .RDATA_WIDTH(32), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_addr_i(m_addr_i),
      .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
      .m_err_pmp_o(m_err_pmp_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_pmp_i(instr_err_pmp_i),
      .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; checks follow 3 units later.
   task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic er);
      @(posedge clk);
      #1;
      m_req_i         = req;
      instr_gnt_i     = gnt;
      instr_rvalid_i  = rv;
      instr_rdata_i   = rd;
      instr_err_pmp_i = er;
      #3;
   endtask

   task automatic expect_rsp(input int id, input logic [31:0] data, input logic err);
      exp_t e;
      e.id = id; e.data = data; e.err = err;
      sb.push_back(e);
   endtask

   // Response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (m_rvalid_o != 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexpected_rvalid", {62'd0, m_rvalid_o}, 64'd0);
            end else begin
               exp_t e;
               logic [1:0] oh;
               e  = sb.pop_front();
               oh = 2'b01 << e.id;
               $display("rsp: rvalid=%b rdata=%h err=%b (exp master %0d data %h err %b)",
                        m_rvalid_o, m_rdata_o, m_err_pmp_o, e.id, e.data, e.err);
               chk("rsp_rvalid", {62'd0, m_rvalid_o}, {62'd0, oh});
               chk("rsp_rdata", {32'd0, m_rdata_o}, {32'd0, e.data});
               chk("rsp_err", {62'd0, m_err_pmp_o}, e.err ? {62'd0, oh} : 64'd0);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; m_req_i = 2'b11; m_addr_i[0] = ADDR0; m_addr_i[1] = ADDR1;
      instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_pmp_i = 1'b0;
      #2;
      chk("rst_req", {63'd0, instr_req_o}, 64'd0);
      chk("rst_gnt", {62'd0, m_gnt_o}, 64'd0);
      chk("rst_out", {62'd0, outstanding_o}, 64'd0);
      chk("rst_perr", {63'd0, protocol_err_o}, 64'd0);
      m_req_i = 2'b00; instr_gnt_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // Single master
      drive(2'b01, 1, 0, 0, 0);
      $display("single: gnt=%b addr=%h", m_gnt_o, instr_addr_o);
      chk("single_req", {63'd0, instr_req_o}, 64'd1);
      chk("single_addr", {32'd0, instr_addr_o}, {32'd0, ADDR0});
      chk("single_gnt", {62'd0, m_gnt_o}, 64'd1);
      chk("single_out0", {62'd0, outstanding_o}, 64'd0);
      expect_rsp(0, 32'h0000_0013, 0);
      drive(2'b00, 0, 1, 32'h0000_0013, 0);
      chk("single_out1", {62'd0, outstanding_o}, 64'd1);
      drive(2'b00, 0, 0, 0, 0);
      chk("single_out2", {62'd0, outstanding_o}, 64'd0);

      // Contention: pointer sits at 1 after master 0's grant
      drive(2'b11, 1, 0, 0, 0);
      $display("cont: gnt=%b", m_gnt_o);
      chk("cont_gnt1", {62'd0, m_gnt_o}, 64'd2);
      chk("cont_addr1", {32'd0, instr_addr_o}, {32'd0, ADDR1});
      expect_rsp(1, 32'hA000_0001, 0);
      drive(2'b11, 1, 1, 32'hA000_0001, 0);
      $display("cont: gnt=%b", m_gnt_o);
      chk("cont_gnt2", {62'd0, m_gnt_o}, 64'd1);
      chk("cont_addr2", {32'd0, instr_addr_o}, {32'd0, ADDR0});
      expect_rsp(0, 32'hA000_0002, 0);
      drive(2'b11, 1, 1, 32'hA000_0002, 0);
      chk("cont_gnt3", {62'd0, m_gnt_o}, 64'd2);
      chk("cont_out3", {62'd0, outstanding_o}, 64'd1);
      expect_rsp(1, 32'hA000_0003, 0);
      drive(2'b11, 1, 1, 32'hA000_0003, 0);
      chk("cont_gnt4", {62'd0, m_gnt_o}, 64'd1);
      expect_rsp(0, 32'hA000_0004, 0);
      drive(2'b00, 0, 1, 32'hA000_0004, 0);
      drive(2'b00, 0, 0, 0, 0);
      chk("cont_out_end", {62'd0, outstanding_o}, 64'd0);

      // PMP error on master 1
      drive(2'b10, 1, 0, 0, 0);
      chk("pmp_gnt", {62'd0, m_gnt_o}, 64'd2);
      expect_rsp(1, 32'hDEAD_BEEF, 1);
      drive(2'b00, 0, 1, 32'hDEAD_BEEF, 1);
      chk("pmp_err_out", {62'd0, m_err_pmp_o}, 64'd2);
      drive(2'b00, 0, 0, 0, 0);

      // Lock: pointer now 0, so unlocked arbitration would prefer master 0
      drive(2'b10, 0, 0, 0, 0);
      chk("lock_req", {63'd0, instr_req_o}, 64'd1);
      chk("lock_addr1", {32'd0, instr_addr_o}, {32'd0, ADDR1});
      chk("lock_gnt1", {62'd0, m_gnt_o}, 64'd0);
      drive(2'b11, 0, 0, 0, 0);
      $display("lock: addr=%h gnt=%b", instr_addr_o, m_gnt_o);
      chk("lock_addr2", {32'd0, instr_addr_o}, {32'd0, ADDR1});
      drive(2'b11, 0, 0, 0, 0);
      chk("lock_addr3", {32'd0, instr_addr_o}, {32'd0, ADDR1});
      drive(2'b11, 1, 0, 0, 0);
      chk("lock_gnt_m1", {62'd0, m_gnt_o}, 64'd2);
      expect_rsp(1, 32'hB000_0001, 0);
      drive(2'b01, 1, 1, 32'hB000_0001, 0);
      chk("lock_gnt_m0", {62'd0, m_gnt_o}, 64'd1);
      chk("lock_addr_m0", {32'd0, instr_addr_o}, {32'd0, ADDR0});
      expect_rsp(0, 32'hB000_0000, 0);
      drive(2'b00, 0, 1, 32'hB000_0000, 0);
      drive(2'b00, 0, 0, 0, 0);

      // Full FIFO
      drive(2'b10, 1, 0, 0, 0);
      chk("full_gnt1", {62'd0, m_gnt_o}, 64'd2);
      drive(2'b10, 1, 0, 0, 0);
      chk("full_gnt2", {62'd0, m_gnt_o}, 64'd2);
      chk("full_out1", {62'd0, outstanding_o}, 64'd1);
      drive(2'b10, 1, 0, 0, 0);
      $display("full: out=%0d req=%b", outstanding_o, instr_req_o);
      chk("full_out2", {62'd0, outstanding_o}, 64'd2);
      chk("full_req_lo", {63'd0, instr_req_o}, 64'd0);
      chk("full_gnt_lo", {62'd0, m_gnt_o}, 64'd0);
      drive(2'b10, 1, 0, 0, 0);
      chk("full_req_lo2", {63'd0, instr_req_o}, 64'd0);
      expect_rsp(1, 32'hC000_0000, 0);
      drive(2'b10, 1, 1, 32'hC000_0000, 0);
      chk("full_req_pop", {63'd0, instr_req_o}, 64'd0);
      drive(2'b10, 1, 0, 0, 0);
      chk("full_req_after", {63'd0, instr_req_o}, 64'd1);
      chk("full_gnt3", {62'd0, m_gnt_o}, 64'd2);
      chk("full_out3", {62'd0, outstanding_o}, 64'd1);
      expect_rsp(1, 32'hC000_0001, 0);
      drive(2'b00, 0, 1, 32'hC000_0001, 0);
      chk("full_out4", {62'd0, outstanding_o}, 64'd2);
      expect_rsp(1, 32'hC000_0002, 0);
      drive(2'b00, 0, 1, 32'hC000_0002, 0);
      drive(2'b00, 0, 0, 0, 0);
      chk("full_out_end", {62'd0, outstanding_o}, 64'd0);

      // Orphan response
      drive(2'b00, 0, 1, 32'h0000_0BAD, 0);
      chk("orph_rvalid", {62'd0, m_rvalid_o}, 64'd0);
      drive(2'b00, 0, 0, 0, 0);
      $display("orphan: protocol_err=%b", protocol_err_o);
      chk("orph_perr", {63'd0, protocol_err_o}, 64'd1);
      drive(2'b00, 0, 0, 0, 0);
      chk("orph_perr_hold", {63'd0, protocol_err_o}, 64'd1);
      chk("orph_out", {62'd0, outstanding_o}, 64'd0);

      // Reset with two outstanding
      drive(2'b01, 1, 0, 0, 0);
      chk("rmid_gnt1", {62'd0, m_gnt_o}, 64'd1);
      drive(2'b01, 1, 0, 0, 0);
      chk("rmid_gnt2", {62'd0, m_gnt_o}, 64'd1);
      drive(2'b01, 1, 0, 0, 0);
      chk("rmid_out2", {62'd0, outstanding_o}, 64'd2);
      @(posedge clk); #1;
      rst = 1'b1; m_req_i = 2'b11; instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1;
      instr_err_pmp_i = 1'b1;
      #3;
      $display("reset: out=%0d req=%b gnt=%b rvalid=%b", outstanding_o, instr_req_o, m_gnt_o, m_rvalid_o);
      chk("rmid_out", {62'd0, outstanding_o}, 64'd0);
      chk("rmid_req", {63'd0, instr_req_o}, 64'd0);
      chk("rmid_gnt", {62'd0, m_gnt_o}, 64'd0);
      chk("rmid_rvalid", {62'd0, m_rvalid_o}, 64'd0);
      chk("rmid_err", {62'd0, m_err_pmp_o}, 64'd0);
      chk("rmid_perr", {63'd0, protocol_err_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; m_req_i = 2'b00; instr_gnt_i = 1'b0; instr_err_pmp_i = 1'b0;
      instr_rvalid_i = 1'b1;
      #3;
      chk("late_rvalid", {62'd0, m_rvalid_o}, 64'd0);
      drive(2'b00, 0, 0, 0, 0);
      chk("late_perr", {63'd0, protocol_err_o}, 64'd1);

      drive(2'b00, 0, 0, 0, 0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
